// File: rtl/ama_riscv_imm_enc.sv
// Packs a 32-bit immediate into I/S/B/J/U instruction fields over a base template and flags unencodable values.
// 2-stage valid/ready pipeline; IMM_ENC_RT_CHECK_EN adds a round-trip decode check (rt_mismatch).
module ama_riscv_imm_enc #(
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2:0]           in_sel,
  input  logic [31:0]          in_imm,
  input  logic [31:0]          in_base,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          out_inst,
  output logic                 out_err,
  output logic [1:0]           out_err_code,
  output logic [ERR_CNT_W-1:0] err_cnt
`ifdef IMM_ENC_RT_CHECK_EN
  ,
  output logic                 rt_mismatch
`endif
);

  localparam logic [2:0] FMT_I = 3'd0;
  localparam logic [2:0] FMT_S = 3'd1;
  localparam logic [2:0] FMT_B = 3'd2;
  localparam logic [2:0] FMT_J = 3'd3;
  localparam logic [2:0] FMT_U = 3'd4;

  localparam logic [1:0] ERR_OK    = 2'd0;
  localparam logic [1:0] ERR_RANGE = 2'd1;
  localparam logic [1:0] ERR_ALIGN = 2'd2;
  localparam logic [1:0] ERR_SEL   = 2'd3;

  logic        s1_valid;
  logic [2:0]  s1_sel;
  logic [31:0] s1_imm;
  logic [31:0] s1_base;
  logic        s2_adv;

  logic [1:0]  s1_code;
  logic [31:0] s1_inst;
  logic        fit11, fit12, fit20;

  assign s2_adv   = !out_valid || out_ready;
  assign in_ready = !s1_valid || s2_adv;

  // Upper bits must all equal the sign bit for the value to survive sign extension.
  assign fit11 = (&s1_imm[31:11]) || !(|s1_imm[31:11]);
  assign fit12 = (&s1_imm[31:12]) || !(|s1_imm[31:12]);
  assign fit20 = (&s1_imm[31:20]) || !(|s1_imm[31:20]);

  always_comb begin
    s1_code = ERR_OK;
    s1_inst = s1_base;
    case (s1_sel)
      FMT_I: begin
        s1_code        = fit11 ? ERR_OK : ERR_RANGE;
        s1_inst[31:20] = s1_imm[11:0];
      end
      FMT_S: begin
        s1_code        = fit11 ? ERR_OK : ERR_RANGE;
        s1_inst[31:25] = s1_imm[11:5];
        s1_inst[11:7]  = s1_imm[4:0];
      end
      FMT_B: begin
        s1_code        = s1_imm[0] ? ERR_ALIGN : (fit12 ? ERR_OK : ERR_RANGE);
        s1_inst[31]    = s1_imm[12];
        s1_inst[30:25] = s1_imm[10:5];
        s1_inst[11:8]  = s1_imm[4:1];
        s1_inst[7]     = s1_imm[11];
      end
      FMT_J: begin
        s1_code        = s1_imm[0] ? ERR_ALIGN : (fit20 ? ERR_OK : ERR_RANGE);
        s1_inst[31]    = s1_imm[20];
        s1_inst[30:21] = s1_imm[10:1];
        s1_inst[20]    = s1_imm[11];
        s1_inst[19:12] = s1_imm[19:12];
      end
      FMT_U: begin
        s1_code        = (|s1_imm[11:0]) ? ERR_ALIGN : ERR_OK;
        s1_inst[31:12] = s1_imm[31:12];
      end
      default: s1_code = ERR_SEL;
    endcase
  end

`ifdef IMM_ENC_RT_CHECK_EN
  logic [31:0] rt_dec;
  logic        rt_bad;

  always_comb begin
    rt_dec = s1_imm;
    case (s1_sel)
      FMT_I: rt_dec = {{20{s1_inst[31]}}, s1_inst[31:20]};
      FMT_S: rt_dec = {{20{s1_inst[31]}}, s1_inst[31:25], s1_inst[11:7]};
      FMT_B: rt_dec = {{19{s1_inst[31]}}, s1_inst[31], s1_inst[7], s1_inst[30:25], s1_inst[11:8], 1'b0};
      FMT_J: rt_dec = {{11{s1_inst[31]}}, s1_inst[31], s1_inst[19:12], s1_inst[20], s1_inst[30:21], 1'b0};
      FMT_U: rt_dec = {s1_inst[31:12], 12'b0};
      default: rt_dec = s1_imm;
    endcase
    rt_bad = (s1_code == ERR_OK) && (rt_dec != s1_imm);
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid     <= 1'b0;
      s1_sel       <= '0;
      s1_imm       <= '0;
      s1_base      <= '0;
      out_valid    <= 1'b0;
      out_inst     <= '0;
      out_err      <= 1'b0;
      out_err_code <= '0;
      err_cnt      <= '0;
`ifdef IMM_ENC_RT_CHECK_EN
      rt_mismatch  <= 1'b0;
`endif
    end else begin
      if (in_ready) s1_valid <= in_valid;
      if (in_valid && in_ready) begin
        s1_sel  <= in_sel;
        s1_imm  <= in_imm;
        s1_base <= in_base;
      end
      if (s2_adv) begin
        out_valid <= s1_valid;
        if (s1_valid) begin
          out_inst     <= s1_inst;
          out_err_code <= s1_code;
          out_err      <= (s1_code != ERR_OK);
`ifdef IMM_ENC_RT_CHECK_EN
          rt_mismatch  <= rt_bad;
`endif
        end
      end
      if (out_valid && out_ready && out_err && (err_cnt != '1))
        err_cnt <= err_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_ama_riscv_imm_enc.sv
// Bench for ama_riscv_imm_enc: directed vector table, backpressure/saturation/reset sequences, random scoreboard.
module tb_ama_riscv_imm_enc;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  in_sel = '0;
  logic [31:0] in_imm = '0;
  logic [31:0] in_base = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_inst;
  logic        out_err;
  logic [1:0]  out_err_code;
  logic [7:0]  err_cnt;
`ifdef IMM_ENC_RT_CHECK_EN
  logic        rt_mismatch;
`endif

  ama_riscv_imm_enc #(.ERR_CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_sel(in_sel), .in_imm(in_imm), .in_base(in_base),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_inst(out_inst), .out_err(out_err), .out_err_code(out_err_code),
    .err_cnt(err_cnt)
`ifdef IMM_ENC_RT_CHECK_EN
    , .rt_mismatch(rt_mismatch)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] inst;
    logic [1:0]  code;
  } exp_t;

  typedef struct {
    logic [2:0]  sel;
    logic [31:0] imm;
    logic [31:0] base;
    logic [31:0] inst;
    logic [1:0]  code;
  } vec_t;

  int   nerr = 0;
  int   nchk = 0;
  int   model_cnt = 0;
  exp_t sbq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    nchk++;
    if (act !== req) begin
      nerr++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  // Which immediate bit lands in instruction bit b for each format (-1: base bit passes through).
  function automatic int src_bit(input logic [2:0] sel, input int b);
    case (sel)
      3'd0: return (b >= 20) ? b - 20 : -1;
      3'd1: return (b >= 25) ? b - 20 : ((b >= 7 && b <= 11) ? b - 7 : -1);
      3'd2: return (b == 31) ? 12 : (b >= 25) ? b - 20 : (b >= 8 && b <= 11) ? b - 7 : (b == 7) ? 11 : -1;
      3'd3: return (b == 31) ? 20 : (b >= 21) ? b - 20 : (b == 20) ? 11 : (b >= 12) ? b : -1;
      3'd4: return (b >= 12) ? b : -1;
      default: return -1;
    endcase
  endfunction

  function automatic exp_t model(input logic [2:0] sel, input logic [31:0] imm, input logic [31:0] base);
    exp_t        e;
    int          s;
    int          lo, hi;
    logic [31:0] align;
    bit          ranged;
    int          src;
    s = $signed(imm);
    lo = 0; hi = 0; align = 1; ranged = 1;
    case (sel)
      3'd0, 3'd1: begin lo = -2048;    hi = 2047;        align = 1;    end
      3'd2:       begin lo = -4096;    hi = 4095;        align = 2;    end
      3'd3:       begin lo = -1048576; hi = 1048575;     align = 2;    end
      3'd4:       begin ranged = 0;                      align = 4096; end
      default: ;
    endcase
    if (sel > 3'd4)                 e.code = 2'd3;
    else if ((imm % align) != 0)    e.code = 2'd2;
    else if (ranged && (s < lo || s > hi)) e.code = 2'd1;
    else                            e.code = 2'd0;
    for (int b = 0; b < 32; b++) begin
      src = src_bit(sel, b);
      e.inst[b] = (src < 0) ? base[b] : imm[src];
    end
    return e;
  endfunction

  // One cycle: drive at negedge, check outputs/handshakes 1ns later, edge commits.
  task automatic step(input logic v, input logic [2:0] sel, input logic [31:0] imm,
                      input logic [31:0] base, input logic ordy, output bit acc);
    exp_t e;
    @(negedge clk);
    in_valid = v; in_sel = sel; in_imm = imm; in_base = base; out_ready = ordy;
    #1;
    chk("err_cnt", 32'(err_cnt), 32'(model_cnt));
`ifdef IMM_ENC_RT_CHECK_EN
    if (out_valid) chk("rt_mismatch", 32'(rt_mismatch), 32'd0);
`endif
    if (out_valid && out_ready) begin
      if (sbq.size() == 0) begin
        nchk++; nerr++;
        $display("FAIL sb_extra: got beat %h want none", out_inst);
      end else begin
        e = sbq.pop_front();
        chk("sb_inst", out_inst, e.inst);
        chk("sb_code", 32'(out_err_code), 32'(e.code));
        chk("sb_err", 32'(out_err), 32'(e.code != 2'd0));
        if (e.code != 2'd0 && model_cnt < 255) model_cnt++;
      end
    end
    acc = v && in_ready;
    if (acc) sbq.push_back(model(sel, imm, base));
  endtask

  task automatic drain();
    bit a;
    for (int i = 0; i < 8 && sbq.size() > 0; i++) step(1'b0, 3'd0, 32'd0, 32'd0, 1'b1, a);
    chk("drain_empty", 32'(sbq.size()), 32'd0);
    step(1'b0, 3'd0, 32'd0, 32'd0, 1'b1, a);
  endtask

  initial begin
    vec_t        tbl[12];
    exp_t        bp_exp[3];
    logic [31:0] held;
    bit          a;
    int          idx;
    logic [31:0] r;
    int          mode;

    tbl[0]  = '{3'd0, 32'hFFFF_F800, 32'h0000_0000, 32'h8000_0000, 2'd0};
    tbl[1]  = '{3'd2, 32'h0000_0FFE, 32'h0000_0000, 32'h7E00_0F80, 2'd0};
    tbl[2]  = '{3'd2, 32'h0000_1001, 32'h0000_0000, 32'h8000_0000, 2'd2};
    tbl[3]  = '{3'd4, 32'h1234_5000, 32'h0000_0037, 32'h1234_5037, 2'd0};
    tbl[4]  = '{3'd3, 32'h0010_0000, 32'h0000_0000, 32'h8000_0000, 2'd1};
    tbl[5]  = '{3'd1, 32'h0000_07FF, 32'h0000_0000, 32'h7E00_0F80, 2'd0};
    tbl[6]  = '{3'd1, 32'h0000_0800, 32'h0000_0000, 32'h8000_0000, 2'd1};
    tbl[7]  = '{3'd5, 32'h1234_5678, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 2'd3};
    tbl[8]  = '{3'd0, 32'h0000_0123, 32'hFFFF_FFFF, 32'h123F_FFFF, 2'd0};
    tbl[9]  = '{3'd3, 32'hFFF0_0000, 32'h0000_006F, 32'h8000_006F, 2'd0};
    tbl[10] = '{3'd4, 32'h0000_0800, 32'h0000_0037, 32'h0000_0037, 2'd2};
    tbl[11] = '{3'd3, 32'h0000_0003, 32'h0000_0000, 32'h0020_0000, 2'd2};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_inst", out_inst, 32'd0);
    chk("rst_err_code", 32'(out_err_code), 32'd0);
    chk("rst_err_cnt", 32'(err_cnt), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Directed vectors with latency check
    foreach (tbl[i]) begin
      @(negedge clk);
      in_valid = 1'b1; in_sel = tbl[i].sel; in_imm = tbl[i].imm; in_base = tbl[i].base; out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("lat_not_yet", 32'(out_valid), 32'd0);
      @(posedge clk); #1;
      chk("lat_valid", 32'(out_valid), 32'd1);
      chk("vec_inst", out_inst, tbl[i].inst);
      chk("vec_code", 32'(out_err_code), 32'(tbl[i].code));
      chk("vec_err", 32'(out_err), 32'(tbl[i].code != 2'd0));
      @(posedge clk); #1;
      if (tbl[i].code != 2'd0 && model_cnt < 255) model_cnt++;
      chk("vec_err_cnt", 32'(err_cnt), 32'(model_cnt));
    end

    // Backpressure: three beats offered, only two fit
    idx = 0;
    for (int k = 0; k < 3; k++) bp_exp[k] = model(3'd0, 32'(k + 1), 32'h0000_0013);
    for (int c = 0; c < 5; c++) begin
      step(1'b1, 3'd0, 32'(idx + 1), 32'h0000_0013, 1'b0, a);
      if (a) idx++;
      if (c == 2) held = out_inst;
      if (c > 2) chk("bp_hold", out_inst, held);
    end
    chk("bp_accepted", 32'(idx), 32'd2);
    chk("bp_in_ready", 32'(in_ready), 32'd0);
    chk("bp_out_valid", 32'(out_valid), 32'd1);
    chk("bp_head", out_inst, bp_exp[0].inst);
    for (int c = 0; c < 3; c++) begin
      step(idx < 3, 3'd0, 32'(idx + 1), 32'h0000_0013, 1'b1, a);
      if (a) idx++;
      chk("bp_stream_valid", 32'(out_valid), 32'd1);
    end
    drain();

    // Saturation with invalid selects
    for (int i = 0; i < 260; i++) step(1'b1, 3'd7, $urandom, 32'(i), 1'b1, a);
    drain();
    chk("sat_err_cnt", 32'(err_cnt), 32'd255);

    // Reset with both stages full
    step(1'b1, 3'd7, 32'd0, 32'h0000_AAAA, 1'b0, a);
    step(1'b1, 3'd7, 32'd0, 32'h0000_BBBB, 1'b0, a);
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_err_cnt", 32'(err_cnt), 32'd0);
    sbq.delete();
    model_cnt = 0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);
    for (int c = 0; c < 4; c++) begin
      step(1'b0, 3'd0, 32'd0, 32'd0, 1'b1, a);
      chk("no_stale", 32'(out_valid), 32'd0);
    end

    // Random traffic against the reference model
    for (int c = 0; c < 600; c++) begin
      r = $urandom;
      mode = $urandom_range(0, 4);
      case (mode)
        0: r = {{20{r[11]}}, r[11:0]};
        1: r = {{11{r[20]}}, r[20:1], 1'b0};
        2: r = {{19{r[12]}}, r[12:1], 1'b0};
        3: r = {r[31:12], 12'b0};
        default: ;
      endcase
      step($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), r, $urandom,
           $urandom_range(0, 9) < 7, a);
    end
    drain();

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
